wb_master_arbiter: RTL

- Two-master to one-slave Wishbone arbiter for the shared register bus on wb_clk.
- Lets the VME-side master (m0) and the local/SPI-side master (m1) share one register slave port, e.g. the in/out control registers.
- Grants the bus round-robin and holds the grant for the whole cyc.
- A watchdog terminates stuck cycles with err, so a missing slave cannot hang either master.

---
 rtl/wb_master_arbiter_pkg.sv | 14 +
 rtl/wb_master_arbiter_watchdog.sv | 46 ++++
 rtl/wb_master_arbiter.sv | 129 ++++++++++++
 3 files changed

// File: rtl/wb_master_arbiter_pkg.sv
// Shared constants for the two-master Wishbone register-bus arbiter.
package wb_master_arbiter_pkg;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    localparam int DEF_TIMEOUT = 64;
    localparam int DEF_TMO_W   = 7;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/wb_master_arbiter_watchdog.sv
// Strobe watchdog: terminates a strobe with err after TIMEOUT cycles without
// ack and keeps a saturating count of those timeouts.
module wb_watchdog
    import wb_master_arbiter_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT,
    parameter int TMO_W   = DEF_TMO_W
) (
    input  logic        wb_clk,
    input  logic        wb_rst,
    input  logic        stb,
    input  logic        ack,
    output logic        tmo_err,
    output logic [15:0] tmo_count
);

    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic [15:0]      tmo_count_q, tmo_count_d;

    // An ack arriving in the final wait cycle wins over the timeout.
    assign tmo_err = stb && !ack && (tmo_cnt_q == TMO_W'(TIMEOUT - 1));

    always_comb begin
        tmo_cnt_d   = tmo_cnt_q + TMO_W'(1);
        tmo_count_d = tmo_count_q;
        if (!stb || ack || tmo_err) begin
            tmo_cnt_d = '0;
        end
        if (tmo_err) begin
            tmo_count_d = sat_inc16(tmo_count_q);
        end
    end

    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            tmo_cnt_q   <= '0;
            tmo_count_q <= '0;
        end else begin
            tmo_cnt_q   <= tmo_cnt_d;
            tmo_count_q <= tmo_count_d;
        end
    end

    assign tmo_count = tmo_count_q;

endmodule

// File: rtl/wb_master_arbiter.sv
// Two-master to one-slave Wishbone arbiter: round-robin grant held for the
// whole cyc, with a watchdog so an absent slave cannot hang a master.
module wb_master_arbiter
    import wb_master_arbiter_pkg::*;
#(
    parameter int ADR_W   = 8,
    parameter int DAT_W   = 32,
    parameter int TIMEOUT = DEF_TIMEOUT,
    parameter int TMO_W   = DEF_TMO_W
) (
    input  logic             wb_clk,
    input  logic             wb_rst,
    input  logic             m0_cyc,
    input  logic             m0_stb,
    input  logic             m0_we,
    input  logic [ADR_W-1:0] m0_adr,
    input  logic [DAT_W-1:0] m0_dat_i,
    output logic [DAT_W-1:0] m0_dat_o,
    output logic             m0_ack,
    output logic             m0_err,
    input  logic             m1_cyc,
    input  logic             m1_stb,
    input  logic             m1_we,
    input  logic [ADR_W-1:0] m1_adr,
    input  logic [DAT_W-1:0] m1_dat_i,
    output logic [DAT_W-1:0] m1_dat_o,
    output logic             m1_ack,
    output logic             m1_err,
    output logic             s_cyc,
    output logic             s_stb,
    output logic             s_we,
    output logic [ADR_W-1:0] s_adr,
    output logic [DAT_W-1:0] s_dat_o,
    input  logic [DAT_W-1:0] s_dat_i,
    input  logic             s_ack,
    output logic             busy,
    output logic             owner,
    output logic [15:0]      tmo_count
);

    logic [0:0] state_q, state_d;
    logic       owner_q, owner_d;
    logic       last_q, last_d;

    logic             granted;
    logic             own_cyc, own_stb, own_we;
    logic [ADR_W-1:0] own_adr;
    logic [DAT_W-1:0] own_dat;
    logic             stb_raw, tmo_err, term_ok, ack_o, err_o;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        case (state_q)
            ST_IDLE: begin
                if (m0_cyc || m1_cyc) begin
                    // On a tie the master that was not served last wins.
                    owner_d = (m0_cyc && m1_cyc) ? ~last_q : m1_cyc;
                    last_d  = owner_d;
                    state_d = ST_GRANT;
                end
            end
            default: begin
                if (!own_cyc) begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            state_q <= ST_IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
        end
    end

    assign granted = (state_q == ST_GRANT);
    assign own_cyc = owner_q ? m1_cyc   : m0_cyc;
    assign own_stb = owner_q ? m1_stb   : m0_stb;
    assign own_we  = owner_q ? m1_we    : m0_we;
    assign own_adr = owner_q ? m1_adr   : m0_adr;
    assign own_dat = owner_q ? m1_dat_i : m0_dat_i;

    assign stb_raw = granted && own_cyc && own_stb;

    wb_watchdog #(
        .TIMEOUT(TIMEOUT),
        .TMO_W  (TMO_W)
    ) u_wdog (
        .wb_clk   (wb_clk),
        .wb_rst   (wb_rst),
        .stb      (stb_raw),
        .ack      (s_ack),
        .tmo_err  (tmo_err),
        .tmo_count(tmo_count)
    );

    assign s_cyc   = granted && own_cyc;
    assign s_stb   = stb_raw && !tmo_err;
    assign s_we    = granted && own_we;
    assign s_adr   = own_adr;
    assign s_dat_o = own_dat;

    // A reset edge aborts the cycle silently, so terminations are masked
    // while wb_rst is asserted.
    assign term_ok = s_cyc && !wb_rst;
    assign ack_o   = term_ok && s_ack;
    assign err_o   = term_ok && tmo_err;

    assign m0_ack  = ack_o && !owner_q;
    assign m1_ack  = ack_o &&  owner_q;
    assign m0_err  = err_o && !owner_q;
    assign m1_err  = err_o &&  owner_q;

    // Read data is broadcast; each master qualifies it with its own ack.
    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;

    assign busy  = granted;
    assign owner = owner_q;

endmodule
